uart_rx_monitor: RTL

//  Receive end of the SoC UART link: decodes 8N1 serial frames from soc0 UART_TXD into bytes.

---
 rtl/uart_rx_monitor_pkg.sv | 17 +
 rtl/uart_rx_monitor_if.sv | 14 +
 rtl/uart_rx_monitor_fifo.sv | 55 +++++
 rtl/uart_rx_monitor.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_monitor_pkg.sv
// Shared types and helpers for the UART receive monitor.
package uart_mon_pkg;

  // Receiver FSM states; also driven out on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_rx_st_t;

  // Core clocks per serial bit.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_monitor_if.sv
// Byte stream leaving the UART receive monitor.
//
// Handshake: the producer (master) holds DATA stable and VALID high until
// the consumer (slave) samples READY high on a rising clock edge; that
// edge is the transfer. VALID never depends on READY, READY may depend on
// VALID, and DATA is only meaningful while VALID is high.
interface uart_rx_monitor_if;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;

  modport master (output DATA, output VALID, input READY);
  modport slave  (input DATA, input VALID, output READY);
endinterface

// File: rtl/uart_rx_monitor_fifo.sv
// First-word-fall-through byte FIFO. A push into a full FIFO is only taken
// when a pop happens in the same cycle; otherwise the caller sees it dropped.
module uart_byte_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so the output is defined from reset.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally; occupancy tracked in a one-bit-wider counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: synchronizes RXD, samples each bit mid-period, and
// queues good bytes into a small FWFT FIFO presented as a valid/ready stream.
module uart_rx_monitor
  import uart_mon_pkg::*;
#(
  parameter int  CLK_HZ      = 100_000_000,
  parameter int  BAUD        = 115200,
  parameter int  FIFO_DEPTH  = 8,
  parameter int  SYNC_STAGES = 2,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                CLK,
  input  logic                RES_N,
  input  logic                RXD,
  uart_rx_monitor_if.master   strm,
  output logic                FERR,
  output logic                OVF,
  input  logic                CLR_OVF,
  output logic                BUSY,
  output logic [CW-1:0]       COUNT,
  output uart_rx_st_t         dbg_state
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = $clog2(DIV);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   rxs;
  logic                   armed_q;
  uart_rx_st_t            state_q, state_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   tick;
  logic                   push;
  logic                   ferr_d;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign tick      = (tmr_q == '0);
  assign BUSY      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  // Line synchronizer; fill_q marks when rxs reflects the real line rather
  // than the reset preset.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      sync_q <= '1;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RXD};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Armed = line genuinely seen high last cycle; a line stuck low after
  // reset or a framing error never produces a start edge.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N)      armed_q <= 1'b0;
    else if (ferr_d) armed_q <= 1'b0;
    else             armed_q <= fill_q[SYNC_STAGES-1] && rxs;
  end

  // FSM, bit timer, bit index and shift register state.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state: start detect at half a bit, then sample every full bit.
  always_comb begin
    state_d = state_q;
    tmr_d   = tick ? tmr_q : tmr_q - TW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && !rxs) begin
          tmr_d   = TW'(DIV / 2 - 1);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rxs) begin
            tmr_d   = TW'(DIV - 1);
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = {rxs, shreg_q[7:1]};
          tmr_d   = TW'(DIV - 1);
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rxs) push   = 1'b1;
          else     ferr_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Framing-error pulse and sticky overflow (a set beats a clear).
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      FERR <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      FERR <= ferr_d;
      if (push && fifo_full && !pop) OVF <= 1'b1;
      else if (CLR_OVF)              OVF <= 1'b0;
    end
  end

  assign strm.VALID = !fifo_empty;
  assign pop        = strm.VALID && strm.READY;

  uart_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RES_N),
    .push  (push),
    .wdata (shreg_q),
    .pop   (pop),
    .rdata (strm.DATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (COUNT)
  );

endmodule
